// File: rtl/addsub_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} addsub_state_t;
  typedef enum logic {OP_ADD, OP_SUB} addsub_op_t;

  // Digit counter width; never below one bit so a single-digit build still has a counter.
  function automatic int cnt_width(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple adder; also exposes the carry into the top bit for overflow.
module addsub_digit
  import addsub_pkg::*;
#(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic c;

  always_comb begin
    sum   = '0;
    c_msb = 1'b0;
    c     = cin;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb = c;
      sum[i] = x[i] ^ y[i] ^ c;
      c      = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
    end
    cout = c;
  end

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor with valid/ready handshakes and registered flags.
// Optional build macro SERIAL_ADDSUB_SAT_EN clamps the result on signed overflow.
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = cnt_width(NDIG);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_chk
    $error("serial_addsub: WIDTH (%0d) must be a multiple of DIGIT (%0d)", WIDTH, DIGIT);
  end

`ifdef SERIAL_ADDSUB_SAT_EN
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0] SMAX = ~SMIN;

  // A wrapped result with the sign bit set means the true value overflowed positive.
  function automatic logic [WIDTH-1:0] sat_result(input logic [WIDTH-1:0] r, input logic ovf);
    if (!ovf) return r;
    return r[WIDTH-1] ? SMAX : SMIN;
  endfunction
`endif

  addsub_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             c_q;
  logic             carry_q, ovf_q, zero_q, neg_q;

  logic             accept, run, last;
  logic [DIGIT-1:0] dsum;
  logic             dcout, dcmsb;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0] res_shift, res_fin;
  logic             ovf_fin;

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .x     (a_q[DIGIT-1:0]),
    .y     (b_q[DIGIT-1:0]),
    .cin   (c_q),
    .sum   (dsum),
    .cout  (dcout),
    .c_msb (dcmsb)
  );

  always_comb begin
    res_cat   = {dsum, res_q};
    res_shift = res_cat[WIDTH+DIGIT-1:DIGIT];
    ovf_fin   = dcmsb ^ dcout;
`ifdef SERIAL_ADDSUB_SAT_EN
    res_fin   = sat_result(res_shift, ovf_fin);
`else
    res_fin   = res_shift;
`endif
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    run       = 1'b0;
    last      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        run = 1'b1;
        if (cnt_q == LAST) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept)   cnt_q <= '0;
      else if (run) cnt_q <= cnt_q + 1'b1;
      if (run) res_q <= last ? res_fin : res_shift;
      if (last) begin
        carry_q <= dcout;
        ovf_q   <= ovf_fin;
        zero_q  <= (res_fin == '0);
        neg_q   <= res_fin[WIDTH-1];
      end
    end
  end

  // Operand shifters: subtraction is a + ~b + 1, the +1 entering as the initial carry.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= (addsub_op_t'(op) == OP_SUB) ? ~b : b;
      c_q <= op;
    end else if (run) begin
      a_q <= a_q >> DIGIT;
      b_q <= b_q >> DIGIT;
      c_q <= dcout;
    end
  end

  assign result   = res_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;
  assign negative = neg_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub (WIDTH=8, DIGIT=2): directed cases plus randomized ops vs an arithmetic model.
module tb_serial_addsub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         carry, overflow, zero, negative;

  int n_cmp = 0;
  int n_bad = 0;

  serial_addsub #(.WIDTH(8), .DIGIT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
    logic         n;
  } exp_t;

  // Reference: exact integer arithmetic, then reduce to 8 bits.
  function automatic exp_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int ux, uy, sx, sy, s;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (!o) begin
      e.c = (ux + uy) > 255;
      s   = sx + sy;
    end else begin
      e.c = (ux >= uy);
      s   = sx - sy;
    end
    e.v   = (s > 127) || (s < -128);
    e.res = 8'(s);
`ifdef SERIAL_ADDSUB_SAT_EN
    if (s > 127)       e.res = 8'h7F;
    else if (s < -128) e.res = 8'h80;
`endif
    e.z = (e.res == 8'h00);
    e.n = e.res[7];
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    check({tag, ".latency"}, lat, 4);
  endtask

  task automatic run_op(input string tag, input logic o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input int hold, output logic [W-1:0] got);
    exp_t e;
    int   lat;
    e = model(o, x, y);
    check({tag, ".in_ready"}, in_ready, 1);
    op = o; a = x; b = y; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    wait_done(tag, lat);
    for (int i = 0; i < hold; i++) step();
    got = result;
    check({tag, ".result"},   result,   e.res);
    check({tag, ".carry"},    carry,    e.c);
    check({tag, ".overflow"}, overflow, e.v);
    check({tag, ".zero"},     zero,     e.z);
    check({tag, ".negative"}, negative, e.n);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, ".idle"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    logic [W-1:0] got;
    int           lat;
    logic         seen;

    step();
    step();
    rst = 1'b0;
    check("reset.outs", {out_valid, result, carry, overflow, zero, negative}, '0);
    check("reset.in_ready", in_ready, 1);

    run_op("t1", 1'b1, 8'h06, 8'h05, 0, got);
    check("t1.lit", got, 8'h01);
    run_op("t2", 1'b1, 8'hFF, 8'hFF, 0, got);
    check("t2.lit", got, 8'h00);
    run_op("t3", 1'b1, 8'h03, 8'h07, 0, got);
    check("t3.lit", got, 8'hFC);
    run_op("t4a", 1'b0, 8'h7F, 8'h01, 0, got);
`ifdef SERIAL_ADDSUB_SAT_EN
    check("t4a.lit", got, 8'h7F);
`else
    check("t4a.lit", got, 8'h80);
`endif
    run_op("t4b", 1'b1, 8'h80, 8'h01, 0, got);
`ifdef SERIAL_ADDSUB_SAT_EN
    check("t4b.lit", got, 8'h80);
`else
    check("t4b.lit", got, 8'h7F);
`endif

    // Backpressure with a competing request pulsed during RUN and DONE.
    op = 1'b0; a = 8'h21; b = 8'h10; in_valid = 1'b1;
    step();
    a = 8'hAA; b = 8'h55;
    wait_done("t5", lat);
    for (int i = 0; i < 3; i++) begin
      check("t5.hold", {out_valid, in_ready, result}, {1'b1, 1'b0, 8'h31});
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t5.idle", {out_valid, in_ready}, 2'b01);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid === 1'b1) seen = 1'b1;
    end
    check("t5.no_second", seen, 0);

    // Reset arriving with the digit counter at 2.
    op = 1'b0; a = 8'h55; b = 8'h66; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6.outs", {out_valid, result, carry, overflow, zero, negative}, '0);
    check("t6.in_ready", in_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid === 1'b1) seen = 1'b1;
    end
    check("t6.no_valid", seen, 0);
    run_op("t6b", 1'b0, 8'h12, 8'h34, 0, got);
    check("t6b.lit", got, 8'h46);

    for (int k = 0; k < 40; k++) begin
      run_op("rnd", 1'($urandom), W'($urandom), W'($urandom), int'($urandom_range(0, 2)), got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
